// File: rtl/attribute_emitter.sv
// rtl/attribute_emitter.sv - serializes an attribute type code and value as "name=digits" plus terminator
//
// Purpose: capture an attribute type and an unsigned value, convert the value to
// BCD (shift-add-3, one bit per cycle), then stream the attribute name, '=',
// the decimal digits (MSD first, leading zeros suppressed) and a terminator,
// one character per out_valid/out_ready handshake.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 request, sampled in IDLE and FIN only
//   in_type, in_value     attribute code and value, captured on accepted start
//   out_char, out_valid   character stream towards the writer
//   out_ready             downstream accepts out_char this cycle
//   busy                  operation in progress (CHECK through TERM)
//   done                  one-cycle pulse at the end of every emission
//   error                 one-cycle pulse with done when the type code is invalid

module attribute_emitter #(
    parameter int          TYPE_W = 4,
    parameter int          VAL_W  = 16,
    parameter int          DIG    = 5,      // must cover ceil(VAL_W*log10(2)) digits
    parameter logic [7:0]  TERM   = 8'h20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [TYPE_W-1:0] in_type,
    input  logic [VAL_W-1:0]  in_value,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CONVERT,
        S_NAME,
        S_EQ,
        S_DIGITS,
        S_TERM,
        S_FIN
    } state_t;

    localparam int                CNT_W    = $clog2(VAL_W + 1);
    // Index serves both as name position (0..9) and digit position (0..DIG-1).
    localparam int                IDX_W    = (DIG > 10) ? $clog2(DIG) : 4;
    localparam logic [TYPE_W-1:0] MAX_TYPE = TYPE_W'(10);

    state_t              state_q, state_d;
    logic [TYPE_W-1:0]   type_q,  type_d;
    logic [VAL_W-1:0]    bin_q,   bin_d;
    logic [4*DIG-1:0]    bcd_q,   bcd_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                err_q,   err_d;

    // Name table: strings left-aligned in 80 bits so character i sits at
    // bits [79-8*i -: 8] regardless of name length.
    logic [79:0]         name_str;
    logic [IDX_W-1:0]    name_len;

    always_comb begin
        name_str = '0;
        name_len = '0;
        case (int'(type_q))
            0:  begin name_str = {"color",      40'h0}; name_len = IDX_W'(5);  end
            1:  begin name_str = {"size",       48'h0}; name_len = IDX_W'(4);  end
            2:  begin name_str = {"width",      40'h0}; name_len = IDX_W'(5);  end
            3:  begin name_str = {"height",     32'h0}; name_len = IDX_W'(6);  end
            4:  begin name_str = {"src",        56'h0}; name_len = IDX_W'(3);  end
            5:  begin name_str = {"href",       48'h0}; name_len = IDX_W'(4);  end
            6:  begin name_str = "background";          name_len = IDX_W'(10); end
            7:  begin name_str = {"padding",    24'h0}; name_len = IDX_W'(7);  end
            8:  begin name_str = {"margin",     32'h0}; name_len = IDX_W'(6);  end
            9:  begin name_str = {"border",     32'h0}; name_len = IDX_W'(6);  end
            10: begin name_str = {"position",   16'h0}; name_len = IDX_W'(8);  end
            default: begin name_str = '0; name_len = '0; end
        endcase
    end

    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift in the
    // next binary MSB.
    logic [4*DIG-1:0] bcd_adj;
    logic [4*DIG-1:0] bcd_shift;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bcd_shift = (bcd_adj << 1) | {{(4*DIG-1){1'b0}}, bin_q[VAL_W-1]};
    end

    // Position of the most significant non-zero digit; 0 when the value is 0,
    // which yields the single "0".
    logic [IDX_W-1:0] msd_idx;

    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd_idx = IDX_W'(i);
            end
        end
    end

    logic [3:0] cur_digit;
    assign cur_digit = bcd_q[4*int'(idx_q) +: 4];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    logic xfer;

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        out_char  = 8'h00;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        xfer      = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (state_q == S_FIN) begin
                    done    = 1'b1;
                    error   = err_q;
                    state_d = S_IDLE;
                end
                // FIN accepts a start too, making back-to-back requests legal.
                if (start) begin
                    type_d  = in_type;
                    bin_d   = in_value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                busy  = 1'b1;
                cnt_d = '0;
                if (type_q > MAX_TYPE) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_CONVERT;
                end
            end

            S_CONVERT: begin
                busy  = 1'b1;
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    idx_d   = '0;
                    state_d = S_NAME;
                end
            end

            S_NAME: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = name_str[79 - 8*int'(idx_q) -: 8];
                xfer      = out_ready;
                if (xfer) begin
                    if (idx_q == name_len - IDX_W'(1)) begin
                        state_d = S_EQ;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_EQ: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = 8'h3D;
                xfer      = out_ready;
                if (xfer) begin
                    idx_d   = msd_idx;
                    state_d = S_DIGITS;
                end
            end

            S_DIGITS: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = {4'h3, cur_digit};
                xfer      = out_ready;
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = S_TERM;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end

            S_TERM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_char  = TERM;
                xfer      = out_ready;
                if (xfer) begin
                    state_d = S_FIN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
